udp_vector_sequencer: RTL and testbench
=======================================

# udp_vector_sequencer

Clocked stimulus-and-scoreboard stage for the UDP gate equivalence check. It drives three four-state sources through all 64 combinations of {0,1,X,Z} into a spec/impl gate pair. After a settle window it strobes a check and compares the eight spec/impl gate outputs with case inequality (`!==`). It accumulates mismatch statistics and records the first failing vector, so the comparison runs unattended and reports a summary.

## Interface
- SETTLE, 4 — cycles each vector is held before sampling; legal range 1..255.
- clk  in  1  — sole clock; all state updates on posedge.
- reset  in  1  — synchronous, active-high.
- start  in  1  — begin a sweep; sampled only in IDLE or DONE.
- src1, src2, src3  out  1 each — four-state stimulus to both gate instances.
- spec_vec  in  8 — spec outputs, bit order [0]not [1]buf [2]and [3]or [4]xor [5]nand [6]nor [7]xnor.
- impl_vec  in  8 — impl outputs, same bit order.
- busy  out  1 — sweep in progress.
- done  out  1 — sweep complete; held until start or reset.
- check  out  1 — one-cycle strobe marking the compare cycle.
- vec_idx  out  6 — current vector {i0,i1,i2}; i0 is bits [5:4].
- mismatch_mask  out  8 — per-gate `!==` result of the last compare.
- gate_fail_mask  out  8 — sticky OR of all mismatch_masks.
- fail_count  out  7 — number of vectors with any mismatch, 0..64.
- first_fail_valid  out  1 — a failure has been recorded.
- first_fail_idx  out  6 — vec_idx of the first failing vector.
- first_fail_mask  out  8 — mismatch_mask of the first failing vector.

## Operation
- Value decode for each 2-bit field: 0→0, 1→1, 2→X, 3→Z.
  - src1 = decode(vec_idx[5:4]), src2 = decode(vec_idx[3:2]), src3 = decode(vec_idx[1:0]).
  - src* are registered outputs.
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE:
  - start=1 → DRIVE; vec_idx=0; settle counter=0; all statistics cleared.
- DRIVE:
  - Counter increments each cycle.
  - When the counter reaches SETTLE-1 → CHECK.
- CHECK:
  - check=1 for exactly this cycle.
  - mismatch_mask is registered as the bitwise `!==` of impl_vec vs spec_vec.
    - X vs X and Z vs Z count as equal.
    - X vs Z, 0 vs X, etc. count as mismatches.
  - If any mismatch bit is set:
    - fail_count increments.
    - gate_fail_mask ORs in the new mask.
    - If first_fail_valid=0, capture first_fail_idx/first_fail_mask and set first_fail_valid.
  - vec_idx=63 → DONE; otherwise vec_idx+1 → DRIVE with the counter cleared.
- DONE:
  - done=1, busy=0; stimulus holds the last vector (Z,Z,Z).
  - start=1 → DRIVE, same clearing as from IDLE.
- start is ignored in DRIVE and CHECK.
- busy=1 in DRIVE and CHECK only.
- fail_count cannot overflow: max 64 fits in 7 bits.

## Timing
- Reset values (reset wins over everything, including mid-sweep): state IDLE, src1/2/3=0, vec_idx=0, busy=0, done=0, check=0, all masks=0, fail_count=0, first_fail_valid=0, first_fail_idx=0.
- start sampled at edge T: busy=1 and vector 0 on src* from T+1.
- Each vector occupies SETTLE DRIVE cycles plus 1 CHECK cycle.
  - The first check is high during cycle T+1+SETTLE.
- Compare samples impl_vec/spec_vec at the end of the CHECK cycle.
  - mismatch_mask and the statistics update visible the cycle after check.
- done rises at T+1+64·(SETTLE+1); busy falls on the same edge.
- The next vector is driven the cycle after CHECK.
- Gate paths must settle within SETTLE cycles; this is the bench's responsibility.

## Test plan
- Reset asserted 3 cycles, then idle 10 cycles with start=0 → all outputs at reset values; no check pulses.
- impl_vec wired to spec_vec, SETTLE=4, start pulse at T → 64 check pulses spaced 5 cycles apart; vec_idx 0..63 in order; done at T+321; fail_count=0; first_fail_valid=0.
- impl_vec equals spec_vec except bit 2 inverted whenever vec_idx[5:2]=4'b0101 → fail_count=4, first_fail_idx=20, first_fail_mask=8'h04, gate_fail_mask=8'h04.
- Case-equality semantics:
  - spec bit 7 forced X and impl bit 7 forced Z on vec_idx=10 only → fail_count=1, first_fail_mask=8'h80.
  - Both forced X on all vectors → fail_count=0.
- reset pulsed while vec_idx=30, plus start pulses during busy → immediate return to reset values; start during busy causes no restart and no stat clear.
- After a failing sweep, start in DONE → stats cleared on the next cycle; a clean second sweep ends with fail_count=0 and gate_fail_mask=0.

Source files
------------

// File: rtl/udp_vector_sequencer.sv
// udp_vector_sequencer: sweeps 64 four-state vectors into a spec/impl gate pair and scores mismatches
module udp_vector_sequencer #(
  parameter int SETTLE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       src1,
  output logic       src2,
  output logic       src3,
  input  logic [7:0] spec_vec,
  input  logic [7:0] impl_vec,
  output logic       busy,
  output logic       done,
  output logic       check,
  output logic [5:0] vec_idx,
  output logic [7:0] mismatch_mask,
  output logic [7:0] gate_fail_mask,
  output logic [6:0] fail_count,
  output logic       first_fail_valid,
  output logic [5:0] first_fail_idx,
  output logic [7:0] first_fail_mask
);
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
  state_t state;
  logic [7:0] cnt;
  logic [7:0] mm;
  // Stimulus is a pure decode of the registered vector index, so it changes only on clock edges
  assign src1 = vec_idx[5:4] == 2'd3 ? 1'bz : vec_idx[5:4] == 2'd2 ? 1'bx : vec_idx[4];
  assign src2 = vec_idx[3:2] == 2'd3 ? 1'bz : vec_idx[3:2] == 2'd2 ? 1'bx : vec_idx[2];
  assign src3 = vec_idx[1:0] == 2'd3 ? 1'bz : vec_idx[1:0] == 2'd2 ? 1'bx : vec_idx[0];
  always_comb begin
    mm = '0;
    for (int i = 0; i < 8; i++) mm[i] = impl_vec[i] !== spec_vec[i];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      vec_idx          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      check            <= 1'b0;
      mismatch_mask    <= '0;
      gate_fail_mask   <= '0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_mask  <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state            <= DRIVE;
          cnt              <= '0;
          vec_idx          <= '0;
          busy             <= 1'b1;
          done             <= 1'b0;
          mismatch_mask    <= '0;
          gate_fail_mask   <= '0;
          fail_count       <= '0;
          first_fail_valid <= 1'b0;
          first_fail_idx   <= '0;
          first_fail_mask  <= '0;
        end
        DRIVE: begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'(SETTLE - 1)) begin
            state <= CHECK;
            check <= 1'b1;
          end
        end
        CHECK: begin
          check         <= 1'b0;
          cnt           <= '0;
          mismatch_mask <= mm;
          if (|mm) begin
            fail_count     <= fail_count + 7'd1;
            gate_fail_mask <= gate_fail_mask | mm;
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_idx   <= vec_idx;
              first_fail_mask  <= mm;
            end
          end
          if (vec_idx == 6'd63) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state   <= DRIVE;
            vec_idx <= vec_idx + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_vector_sequencer.sv
// tb_udp_vector_sequencer: gate-pair model with fault injection and a per-vector mismatch scoreboard
module tb_udp_vector_sequencer;
  localparam int SETTLE = 4;
  localparam logic LX = 1'bx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic src1, src2, src3;
  logic [7:0] spec_vec, impl_vec, gates;
  logic busy, done, check, first_fail_valid;
  logic [5:0] vec_idx, first_fail_idx;
  logic [7:0] mismatch_mask, gate_fail_mask, first_fail_mask;
  logic [6:0] fail_count;
  wire zw = 1'bz;
  int cyc = 0;
  int mode = 0;
  int checks = 0;
  int passed = 0;
  logic [7:0] exp_q[$];
  int m_fail;
  logic [7:0] m_gate, m_ffm;
  logic m_ffv;
  logic [5:0] m_ffi;

  udp_vector_sequencer #(.SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src1(src1), .src2(src2), .src3(src3),
    .spec_vec(spec_vec), .impl_vec(impl_vec),
    .busy(busy), .done(done), .check(check), .vec_idx(vec_idx),
    .mismatch_mask(mismatch_mask), .gate_fail_mask(gate_fail_mask),
    .fail_count(fail_count), .first_fail_valid(first_fail_valid),
    .first_fail_idx(first_fail_idx), .first_fail_mask(first_fail_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate pair: {xnor, nor, nand, xor, or, and, buf, not}, with faults injected on the impl side
  always_comb begin
    gates = {~(src1 ^ src2 ^ src3), ~(src1 | src2 | src3), ~(src1 & src2 & src3),
             src1 ^ src2 ^ src3, src1 | src2 | src3, src1 & src2 & src3, src1, ~src1};
    spec_vec = gates;
    impl_vec = gates;
    if (mode == 1 && vec_idx[5:2] == 4'b0101) impl_vec[2] = (gates[2] === 1'b1) ? 1'b0 : 1'b1;
    if (mode == 2 && vec_idx == 6'd10) begin
      spec_vec[7] = LX;
      impl_vec[7] = zw;
    end
    if (mode == 3) begin
      spec_vec[7] = LX;
      impl_vec[7] = LX;
    end
  end

  task automatic sweep(input string tag);
    int t0, k;
    logic [7:0] e;
    @(negedge clk) start = 1'b1;
    t0 = cyc;
    @(negedge clk) start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || fail_count !== 7'd0 || gate_fail_mask !== 8'h00 || first_fail_valid !== 1'b0)
      $display("FAIL %s start_clear: busy=%b done=%b fail_count=%0d gmask=%h ffv=%b, want 1 0 0 00 0", tag, busy, done, fail_count, gate_fail_mask, first_fail_valid);
    else passed++;
    m_fail = 0; m_gate = '0; m_ffv = 1'b0; m_ffi = '0; m_ffm = '0;
    exp_q.delete();
    k = 0;
    for (int n = 0; n < 600; n++) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (mismatch_mask !== e) $display("FAIL %s mask vec %0d: got %h want %h", tag, k - 1, mismatch_mask, e);
        else passed++;
      end
      if (done) break;
      if (check) begin
        checks++;
        if (vec_idx !== 6'(k) || cyc - t0 != 1 + SETTLE + k * (SETTLE + 1))
          $display("FAIL %s check_pulse %0d: idx=%0d at +%0d, want idx=%0d at +%0d", tag, k, vec_idx, cyc - t0, k, 1 + SETTLE + k * (SETTLE + 1));
        else passed++;
        for (int i = 0; i < 8; i++) e[i] = impl_vec[i] !== spec_vec[i];
        exp_q.push_back(e);
        if (|e) begin
          m_fail++;
          m_gate |= e;
          if (!m_ffv) begin
            m_ffv = 1'b1; m_ffi = vec_idx; m_ffm = e;
          end
        end
        k++;
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || k != 64 || cyc - t0 != 1 + 64 * (SETTLE + 1))
      $display("FAIL %s done_time: done=%b busy=%b checks=%0d at +%0d, want 1 0 64 at +%0d", tag, done, busy, k, cyc - t0, 1 + 64 * (SETTLE + 1));
    else passed++;
    checks++;
    if (fail_count !== 7'(m_fail) || gate_fail_mask !== m_gate || first_fail_valid !== m_ffv ||
        (m_ffv && (first_fail_idx !== m_ffi || first_fail_mask !== m_ffm)))
      $display("FAIL %s stats: got cnt=%0d g=%h v=%b i=%0d m=%h want cnt=%0d g=%h v=%b i=%0d m=%h", tag,
               fail_count, gate_fail_mask, first_fail_valid, first_fail_idx, first_fail_mask, m_fail, m_gate, m_ffv, m_ffi, m_ffm);
    else passed++;
  endtask

  task automatic test_reset();
    int pulses = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (check) pulses++;
    end
    checks++;
    if (pulses != 0) $display("FAIL reset_no_check: got %0d pulses want 0", pulses);
    else passed++;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || check !== 1'b0 || vec_idx !== 6'd0)
      $display("FAIL reset_ctrl: busy=%b done=%b check=%b idx=%0d want 0 0 0 0", busy, done, check, vec_idx);
    else passed++;
    checks++;
    if ({src1, src2, src3} !== 3'b000) $display("FAIL reset_src: got %b want 000", {src1, src2, src3});
    else passed++;
    checks++;
    if (mismatch_mask !== 8'h00 || gate_fail_mask !== 8'h00 || first_fail_mask !== 8'h00)
      $display("FAIL reset_masks: got %h %h %h want 00 00 00", mismatch_mask, gate_fail_mask, first_fail_mask);
    else passed++;
    checks++;
    if (fail_count !== 7'd0 || first_fail_valid !== 1'b0 || first_fail_idx !== 6'd0)
      $display("FAIL reset_stats: got %0d %b %0d want 0 0 0", fail_count, first_fail_valid, first_fail_idx);
    else passed++;
  endtask

  task automatic test_clean();
    mode = 0;
    sweep("clean");
    checks++;
    if (fail_count !== 7'd0 || first_fail_valid !== 1'b0)
      $display("FAIL clean_result: got cnt=%0d ffv=%b want 0 0", fail_count, first_fail_valid);
    else passed++;
  endtask

  task automatic test_gate_fault();
    mode = 1;
    sweep("and_fault");
    checks++;
    if (fail_count !== 7'd4 || first_fail_idx !== 6'd20 || first_fail_mask !== 8'h04 || gate_fail_mask !== 8'h04 || first_fail_valid !== 1'b1)
      $display("FAIL and_fault_result: got cnt=%0d idx=%0d m=%h g=%h want 4 20 04 04", fail_count, first_fail_idx, first_fail_mask, gate_fail_mask);
    else passed++;
  endtask

  task automatic test_case_eq();
    mode = 2;
    sweep("x_vs_z");
    mode = 3;
    sweep("x_vs_x");
    checks++;
    if (fail_count !== 7'd0) $display("FAIL x_vs_x_result: got %0d want 0", fail_count);
    else passed++;
  endtask

  task automatic test_restart();
    mode = 1;
    sweep("restart_fail");
    mode = 0;
    sweep("restart_clean");
    checks++;
    if (fail_count !== 7'd0 || gate_fail_mask !== 8'h00)
      $display("FAIL restart_result: got cnt=%0d g=%h want 0 00", fail_count, gate_fail_mask);
    else passed++;
  endtask

  task automatic test_midsweep_reset();
    int n;
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (n = 0; n < 1000 && vec_idx != 6'd30; n++) @(negedge clk);
    checks++;
    if (vec_idx !== 6'd30) $display("FAIL mid_reach30: got idx=%0d want 30", vec_idx);
    else passed++;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++;
    if (busy !== 1'b1 || vec_idx !== 6'd30 || fail_count !== 7'd4 || first_fail_idx !== 6'd20)
      $display("FAIL mid_start_ignored: busy=%b idx=%0d cnt=%0d ffi=%0d want 1 30 4 20", busy, vec_idx, fail_count, first_fail_idx);
    else passed++;
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || check !== 1'b0 || vec_idx !== 6'd0 || fail_count !== 7'd0 ||
        gate_fail_mask !== 8'h00 || first_fail_valid !== 1'b0 || first_fail_idx !== 6'd0 || {src1, src2, src3} !== 3'b000)
      $display("FAIL mid_reset: busy=%b done=%b idx=%0d cnt=%0d g=%h ffv=%b src=%b want all zero", busy, done, vec_idx, fail_count, gate_fail_mask, first_fail_valid, {src1, src2, src3});
    else passed++;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || vec_idx !== 6'd0) $display("FAIL mid_stays_idle: busy=%b idx=%0d want 0 0", busy, vec_idx);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_gate_fault();
    test_case_eq();
    test_restart();
    test_midsweep_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
